snell_loader: RTL and testbench
===============================

# snell_loader

Host-side sequencer for the `snell_law` core's shared-port load protocol. It accepts one parameter set (n2, theta1, theta2) over a valid/ready command interface and drives the core's one-hot select strobes and shared 7-bit `input_port`, each for a fixed hold time. It then asserts `out_sel`, captures the core's `output_port`, and returns the result over a valid/ready response interface. It sits between the system controller and `snell_law`, replacing hand-driven testbench stimulus.

## Interface
- `DW`, 7: data width of the shared port, the command fields and the result.
- `HOLD`, 10: cycles each load select is held, ≥1.
- `LAT`, 4: cycles `out_sel` is held before capture, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: loader can accept a command.
- `cmd_n2` in DW: refractive-index code.
- `cmd_t1` in DW: theta1 code.
- `cmd_t2` in DW: theta2 code.
- `n2_sel`, `t1_sel`, `t2_sel`, `out_sel` out 1 each: strobes to `snell_law`.
- `input_port` out DW: shared data to `snell_law`.
- `output_port` in DW: result from `snell_law`.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts result.
- `res_data` out DW: captured result.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE → LD_N2 → LD_T1 → LD_T2 → READ → RESP → IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch all three fields and go to LD_N2 with the timer loaded to HOLD.
- LD_N2, LD_T1, LD_T2: the matching select is 1 and `input_port` carries the latched field.
  - Each state lasts exactly HOLD cycles, then advances.
- READ: `out_sel`=1 and `input_port`=0 for LAT cycles.
  - On the clock edge ending the last READ cycle, `res_data` ← `output_port`.
- RESP: `res_valid`=1 and all selects are 0. `res_data` is held stable until `res_valid && res_ready`, then the FSM returns to IDLE.
- Select invariants:
  - At most one of the four selects is high in any cycle.
  - `input_port`=0 whenever no load select is high.
- Commands are never queued. `cmd_valid` outside IDLE is ignored, and the command source holds it.
- All outputs are registered. Fields are used unmodified, with no arithmetic on data.
- Timer: a down-counter of width $clog2(max(HOLD,LAT)+1), reloaded on every state entry.

## Timing
- Reset (`rst`=0 at a rising edge): state=IDLE, all selects 0, `input_port`=0, `res_valid`=0, `res_data`=0, `busy`=0.
  - `cmd_ready`=0 while `rst`=0, and 1 in the first cycle after release.
- Reset mid-operation: any state is abandoned at that edge, the latched command is discarded, and no response is produced.
- With acceptance at edge k:
  - `n2_sel` is high in cycles k+1 … k+HOLD.
  - `t1_sel` follows for HOLD cycles, then `t2_sel` for HOLD cycles.
  - `out_sel` is high for LAT cycles.
  - `res_valid` first rises 3·HOLD+LAT+1 cycles after k.
- `res_ready` already high when `res_valid` rises: the handshake completes in that cycle, the FSM is in IDLE next cycle, and `cmd_ready`=1 there.
  - Minimum command-to-command spacing is 3·HOLD+LAT+2 cycles.
- `res_ready` low: the FSM stays in RESP indefinitely. `res_data` and `res_valid` are stable and `out_sel` stays 0.

## Structure
- Package `snell_pkg` holds:
  - the DW constant (7);
  - the state enum `loader_state_t`;
  - the HOLD and LAT default constants, which `snell_law`-side benches also use.
- One sub-module, `hold_timer`: a loadable down-counter with a `load`/`value` input and a `done` output (count==1). It is shared by the load and READ phases.
- Everything else lives in the top module: FSM, command latch, output registers.

## Test plan
Parameters for all scenarios: HOLD=10, LAT=4, and a `snell_law` stub that returns a fixed value.
- Basic load: reset for 10 cycles, then command n2=10, t1=1, t2=1, stub output=0x2A.
  - Required: `n2_sel` high for 10 cycles with `input_port`=10, then `t1_sel` ×10 with 1, then `t2_sel` ×10 with 1, then `out_sel` ×4.
  - Required: `res_valid` rises at cycle 35 with `res_data`=0x2A.
- Backpressure: hold `res_ready`=0 for 20 cycles.
  - Required: `res_valid`=1 and `res_data` stable, all selects 0, `cmd_ready`=0.
  - Required: handshake on the release cycle, and `cmd_ready`=1 the next cycle.
- Busy command: pulse `cmd_valid` with n2=99 while in LD_T1.
  - Required: ignored, and the sequence and fields are unchanged.
- Mid-operation reset: assert `rst`=0 for one edge during READ.
  - Required: next cycle all outputs are 0, `res_valid` never rises, and `cmd_ready`=1 after release.
- Back-to-back: two commands with `res_ready` tied high.
  - Required: the second is accepted exactly 36 cycles after the first.
  - Required: the one-hot select invariant is checked every cycle.

Source files
------------

// File: rtl/snell_pkg.sv
// Shared constants and state encoding for the snell_law load sequencer.
package snell_pkg;

  // Width of the shared input port, the command fields and the result.
  localparam int SNELL_DW   = 7;
  // Default number of cycles each load select is held.
  localparam int SNELL_HOLD = 10;
  // Default number of cycles out_sel is held before the result is captured.
  localparam int SNELL_LAT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LD_N2 = 3'd1,
    ST_LD_T1 = 3'd2,
    ST_LD_T2 = 3'd3,
    ST_READ  = 3'd4,
    ST_RESP  = 3'd5
  } loader_state_t;

  // Larger of two integers; used to size the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that times each load/read phase of the loader.
// done is high in the last cycle of a phase (count == 1).
module hold_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] count;

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == TW'(1));

endmodule

// File: rtl/snell_loader.sv
// Host-side sequencer for the snell_law shared-port load protocol.
// Accepts one (n2, theta1, theta2) command, strobes each field into the core
// for HOLD cycles, raises out_sel for LAT cycles, captures output_port and
// returns it on the response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_ready is high only in IDLE; a command source must hold
// cmd_valid and its fields stable until the transfer. res_valid is held with
// res_data stable until the edge where res_ready is also high.
module snell_loader
  import snell_pkg::*;
#(
  parameter int DW   = SNELL_DW,
  parameter int HOLD = SNELL_HOLD,
  parameter int LAT  = SNELL_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_n2,
  input  logic [DW-1:0] cmd_t1,
  input  logic [DW-1:0] cmd_t2,
  output logic          n2_sel,
  output logic          t1_sel,
  output logic          t2_sel,
  output logic          out_sel,
  output logic [DW-1:0] input_port,
  input  logic [DW-1:0] output_port,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic [2:0]    state_dbg
);

  localparam int TW = $clog2(max_int(HOLD, LAT) + 1);

  loader_state_t state, next_state;

  logic [DW-1:0] n2_q, t1_q, t2_q;

  logic          accept;
  logic          capture;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_done;

  logic          nxt_n2_sel, nxt_t1_sel, nxt_t2_sel, nxt_out_sel;
  logic [DW-1:0] nxt_input_port;
  logic          nxt_res_valid, nxt_busy, nxt_cmd_ready;

  hold_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // Next state, phase timer control and next values of the registered outputs.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    capture        = 1'b0;
    nxt_input_port = '0;

    case (state)
      ST_IDLE: begin
        accept = cmd_valid && cmd_ready;
        if (accept) next_state = ST_LD_N2;
      end
      ST_LD_N2: if (timer_done) next_state = ST_LD_T1;
      ST_LD_T1: if (timer_done) next_state = ST_LD_T2;
      ST_LD_T2: if (timer_done) next_state = ST_READ;
      ST_READ: begin
        capture = timer_done;
        if (timer_done) next_state = ST_RESP;
      end
      ST_RESP: if (res_valid && res_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase

    // Every state entry restarts the timer; only READ uses the LAT length.
    timer_load  = (next_state != state);
    timer_value = (next_state == ST_READ) ? TW'(LAT) : TW'(HOLD);

    nxt_n2_sel    = (next_state == ST_LD_N2);
    nxt_t1_sel    = (next_state == ST_LD_T1);
    nxt_t2_sel    = (next_state == ST_LD_T2);
    nxt_out_sel   = (next_state == ST_READ);
    nxt_res_valid = (next_state == ST_RESP);
    nxt_busy      = (next_state != ST_IDLE);
    nxt_cmd_ready = (next_state == ST_IDLE);

    // The n2 field is driven straight from the command on the accepting edge,
    // since the latch is being written on that same edge.
    case (next_state)
      ST_LD_N2: nxt_input_port = accept ? cmd_n2 : n2_q;
      ST_LD_T1: nxt_input_port = t1_q;
      ST_LD_T2: nxt_input_port = t2_q;
      default:  nxt_input_port = '0;
    endcase
  end

  // State register and registered outputs; reset abandons any command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      n2_sel     <= 1'b0;
      t1_sel     <= 1'b0;
      t2_sel     <= 1'b0;
      out_sel    <= 1'b0;
      input_port <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      cmd_ready  <= 1'b0;
      res_data   <= '0;
    end else begin
      state      <= next_state;
      n2_sel     <= nxt_n2_sel;
      t1_sel     <= nxt_t1_sel;
      t2_sel     <= nxt_t2_sel;
      out_sel    <= nxt_out_sel;
      input_port <= nxt_input_port;
      res_valid  <= nxt_res_valid;
      busy       <= nxt_busy;
      cmd_ready  <= nxt_cmd_ready;
      if (capture) res_data <= output_port;
    end
  end

  // Command latch; written only on an accepted command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      n2_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
    end else if (accept) begin
      n2_q <= cmd_n2;
      t1_q <= cmd_t1;
      t2_q <= cmd_t2;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_snell_loader.sv
// Self-checking bench for snell_loader with a fixed-value snell_law stub.
module tb_snell_loader;
  import snell_pkg::*;

  localparam int DW = 7;
  localparam int H  = 10;
  localparam int L  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_n2 = '0, cmd_t1 = '0, cmd_t2 = '0;
  logic          n2_sel, t1_sel, t2_sel, out_sel;
  logic [DW-1:0] input_port;
  logic [DW-1:0] stub = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          busy;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int first_acc = 0;

  snell_loader #(.DW(DW), .HOLD(H), .LAT(L)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_n2      (cmd_n2),
    .cmd_t1      (cmd_t1),
    .cmd_t2      (cmd_t2),
    .n2_sel      (n2_sel),
    .t1_sel      (t1_sel),
    .t2_sel      (t2_sel),
    .out_sel     (out_sel),
    .input_port  (input_port),
    .output_port (stub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+6:0] obs_vec();
    return {n2_sel, t1_sel, t2_sel, out_sel, res_valid, busy, cmd_ready, input_port};
  endfunction

  // Reference model: which phase a cycle d after acceptance belongs to.
  // 0 idle, 1 n2 load, 2 t1 load, 3 t2 load, 4 read, 5 response.
  function automatic int phase_of(input int d);
    if (d <= H)         return 1;
    if (d <= 2 * H)     return 2;
    if (d <= 3 * H)     return 3;
    if (d <= 3 * H + L) return 4;
    return 5;
  endfunction

  function automatic logic [DW+6:0] exp_vec(input int ph, input logic [DW-1:0] n2,
                                            input logic [DW-1:0] t1, input logic [DW-1:0] t2);
    logic [DW-1:0] ip;
    ip = (ph == 1) ? n2 : (ph == 2) ? t1 : (ph == 3) ? t2 : '0;
    return {ph == 1, ph == 2, ph == 3, ph == 4, ph == 5, ph != 0, ph == 0, ip};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge and check the select invariants there.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("onehot", 32'($countones({n2_sel, t1_sel, t2_sel, out_sel}) <= 1), 32'd1);
    chk("port_zero_when_unselected",
        32'(!(n2_sel || t1_sel || t2_sel) && (input_port != '0)), 32'd0);
  endtask

  // Issue one command and follow it through every phase.
  // bp: cycles res_ready is held low; poke: stray command during LD_T1;
  // rst_at: if nonzero, reset for one edge at that cycle offset.
  task automatic run_cmd(input logic [DW-1:0] n2, input logic [DW-1:0] t1,
                         input logic [DW-1:0] t2, input logic [DW-1:0] rv,
                         input int bp, input bit poke, input int rst_at);
    bit got;
    got = 1'b0;
    stub = rv;
    cmd_n2 = n2; cmd_t1 = t1; cmd_t2 = t2;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (cmd_ready === 1'b1) got = 1'b1;
      else step();
    end
    chk("accept_within_bound", 32'(got), 32'd1);
    if (!got) begin
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    step();
    cmd_valid = 1'b0;
    for (int d = 1; d <= 3 * H + L; d++) begin
      if (d > 1) step();
      chk($sformatf("phase_d%0d", d), 32'(obs_vec()), 32'(exp_vec(phase_of(d), n2, t1, t2)));
      if (poke && d == H + 3) begin
        cmd_valid = 1'b1; cmd_n2 = 7'd99; cmd_t1 = ~t1; cmd_t2 = ~t2;
      end
      if (poke && d == H + 4) begin
        cmd_valid = 1'b0; cmd_n2 = n2; cmd_t1 = t1; cmd_t2 = t2;
      end
      if (rst_at != 0 && d == rst_at) begin
        rst = 1'b0;
        step();
        chk("midop_reset_outputs_zero", 32'({obs_vec(), res_data}), 32'd0);
        rst = 1'b1;
        step();
        chk("midop_release_ready", 32'(cmd_ready), 32'd1);
        for (int j = 0; j < 40; j++) begin
          step();
          chk("midop_no_response", 32'(res_valid), 32'd0);
        end
        return;
      end
    end
    step();
    for (int j = 0; j <= bp; j++) begin
      chk($sformatf("resp_hold_%0d", j), 32'(obs_vec()), 32'(exp_vec(5, n2, t1, t2)));
      chk($sformatf("resp_data_%0d", j), 32'(res_data), 32'(rv));
      if (j < bp) stub = 7'($urandom);
      res_ready = (j == bp);
      step();
    end
    chk("idle_after_handshake", 32'(obs_vec()), 32'(exp_vec(0, n2, t1, t2)));
    chk("res_data_kept", 32'(res_data), 32'(rv));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    repeat (10) step();
    chk("reset_outputs", 32'({obs_vec(), res_data}), 32'd0);
    chk("reset_state_idle", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    step();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);

    // Basic load.
    run_cmd(7'd10, 7'd1, 7'd1, 7'h2A, 0, 1'b0, 0);

    // Backpressure for 20 cycles.
    run_cmd(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 20, 1'b0, 0);

    // Stray command while loading theta1.
    run_cmd(7'd5, 7'd66, 7'd120, 7'h15, 2, 1'b1, 0);

    // Reset during READ.
    run_cmd(7'($urandom), 7'($urandom), 7'($urandom), 7'h7F, 0, 1'b0, 3 * H + 2);

    // Back-to-back with res_ready high.
    res_ready = 1'b1;
    run_cmd(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 0, 1'b0, 0);
    first_acc = last_acc;
    run_cmd(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 0, 1'b0, 0);
    chk("back_to_back_spacing", 32'(last_acc - first_acc), 32'(3 * H + L + 2));

    // Random commands with random backpressure and idle gaps.
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 3)) step();
      run_cmd(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
              $urandom_range(0, 6), 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
